pwm_compare: RTL and testbench
==============================

Name: pwm_compare

Overview:
- Multi-channel compare/PWM stage directly downstream of the counter block.
- Consumes the counter's count value, its enable and its up_down direction. Compares the count against per-channel compare registers and produces PWM levels, single-cycle match pulses and a period-boundary pulse.
- Compare values are double-buffered: software writes go to shadow registers and are committed atomically at the next period boundary.

Parameters:
- COUNT_WIDTH, 4, width of count and compare values; must match the upstream counter.
- NUM_CH, 2, number of compare channels (1..8).
- COUNT_START, 2, counter low wrap value; must match the upstream counter.
- COUNT_END, 11, counter high wrap value; must match the upstream counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- count_en  in  1  same enable that drives the upstream counter; high = count advances this edge.
- up_down  in  1  counter direction; 1 = up, 0 = down.
- count  in  COUNT_WIDTH  current counter value.
- cmp_wr_en  in  1  write strobe for a shadow compare register.
- cmp_wr_sel  in  max(1,$clog2(NUM_CH))  channel index; out-of-range index ignored.
- cmp_wr_data  in  COUNT_WIDTH  compare value.
- pwm_out  out  NUM_CH  registered PWM level per channel.
- match_pulse  out  NUM_CH  registered one-cycle pulse per channel.
- period_pulse  out  1  registered one-cycle pulse at period boundary.
- update_pending  out  1  shadow values not yet committed.
- update_done  out  1  one-cycle pulse when shadow values are committed.

Behaviour:
- Reset (rst low, asynchronous):
  - All outputs are 0.
  - cmp_active[i] and cmp_shadow[i] are set to COUNT_START.
  - Update FSM is in IDLE.
- Boundary condition:
  - boundary = count_en && ((up_down && count==COUNT_END) || (!up_down && count==COUNT_START)).
  - period_pulse is boundary registered; latency 1 cycle.
- PWM output:
  - Each edge: pwm_out[i] <= (count < cmp_active[i]); latency 1 cycle.
  - Updated regardless of count_en, so a held count gives a held level.
  - Comparison is unsigned at COUNT_WIDTH.
  - cmp <= COUNT_START gives a constant 0; cmp > COUNT_END gives a constant 1.
- Match pulse:
  - match_pulse[i] <= count_en && (count == cmp_active[i]).
  - No pulses while count_en is low.
- Update FSM has two states, IDLE and PENDING:
  - IDLE: on a valid cmp_wr_en, write cmp_shadow[sel] and go to PENDING.
  - PENDING: on boundary, copy all cmp_shadow to cmp_active, pulse update_done for 1 cycle, go to IDLE.
  - PENDING: a write without boundary overwrites the shadow and stays in PENDING.
- Simultaneous write and boundary:
  - The commit uses the shadow contents from before this edge.
  - The write lands in the shadow and the FSM stays in PENDING for the next boundary.
  - update_done still pulses.
- A new cmp_active first affects pwm_out and match_pulse on the edge after the commit.
- update_pending = (state == PENDING), registered.
- Reset mid-period discards pending shadow values. Outputs drop to 0 asynchronously and stay 0 until the first clock after reset release.
- Out-of-range cmp_wr_sel: no state change.

Optional Feature:
Macro PWM_COMPARE_IRQ_EN.
- Defined:
  - Adds output irq (1) and input irq_clr (1).
  - irq is a sticky register, set on any match_pulse bit or update_done, cleared by irq_clr.
  - Set wins over a simultaneous clear.
  - Reset value 0.
- Undefined: the ports and logic are absent; all other behaviour is unchanged.

Test Plan:
All scenarios use the upstream counter with step 1 between 2 and 11, up-counting, count_en=1, unless stated.
- Reset release with no writes -> pwm_out=00 for all cycles; period_pulse one cycle high every 10 cycles, 1 cycle after count==11; update_pending=0.
- Write ch0=6 mid-period (count=4) -> update_pending=1 until the boundary; update_done pulses 1 cycle after count==11. From the next period, pwm_out[0]=1 for 4 cycles (counts 2..5) and 0 for 6 cycles; match_pulse[0] fires once per period, 1 cycle after count==6.
- Write ch1=12 and ch1=2, then ch0=9 in the same pending window -> at commit cmp_active={ch1=2, ch0=9}; pwm_out[1] stays 0; pwm_out[0] high 7 of 10 cycles.
- Write ch0=8 on the exact cycle count==11 with an earlier pending ch0=5 -> this boundary commits 5 and update_pending stays 1; the next boundary commits 8.
- Down-counting (up_down=0) with ch0=7 -> boundary at count==2; pwm_out[0]=1 for counts 6..2. Deassert count_en at count=5 for 3 cycles -> pwm_out held, no match or period pulses.
- Assert rst low while pending at count=9 -> all outputs 0 immediately. After release, ch0 is still COUNT_START (pwm_out[0]=0) and update_pending=0.
  - With PWM_COMPARE_IRQ_EN defined, also check: irq set by the first match; irq_clr coinciding with a match leaves irq=1.

Source files
------------

// File: rtl/pwm_compare.sv
// Multi-channel compare/PWM stage fed by the up/down counter, with shadow compare
// registers committed at the period boundary. Optional irq logic: PWM_COMPARE_IRQ_EN.

module pwm_compare_ch #(
   parameter int COUNT_WIDTH = 4,
   parameter int COUNT_START = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   count_en,
   input  logic [COUNT_WIDTH-1:0] count,
   input  logic                   wr_en,
   input  logic [COUNT_WIDTH-1:0] wr_data,
   input  logic                   commit,
   output logic                   pwm_out,
   output logic                   match_pulse
);

   logic [COUNT_WIDTH-1:0] cmp_active;
   logic [COUNT_WIDTH-1:0] cmp_shadow;

   // commit samples the old shadow, so a coincident write waits for the next boundary
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cmp_active  <= COUNT_WIDTH'(COUNT_START);
         cmp_shadow  <= COUNT_WIDTH'(COUNT_START);
         pwm_out     <= 1'b0;
         match_pulse <= 1'b0;
      end else begin
         pwm_out     <= (count < cmp_active);
         match_pulse <= count_en && (count == cmp_active);
         if (commit)
            cmp_active <= cmp_shadow;
         if (wr_en)
            cmp_shadow <= wr_data;
      end
   end

endmodule

module pwm_compare #(
   parameter  int COUNT_WIDTH = 4,
   parameter  int NUM_CH      = 2,
   parameter  int COUNT_START = 2,
   parameter  int COUNT_END   = 11,
   localparam int SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   count_en,
   input  logic                   up_down,
   input  logic [COUNT_WIDTH-1:0] count,
   input  logic                   cmp_wr_en,
   input  logic [SEL_W-1:0]       cmp_wr_sel,
   input  logic [COUNT_WIDTH-1:0] cmp_wr_data,
   output logic [NUM_CH-1:0]      pwm_out,
   output logic [NUM_CH-1:0]      match_pulse,
   output logic                   period_pulse,
   output logic                   update_pending,
   output logic                   update_done
`ifdef PWM_COMPARE_IRQ_EN
   ,
   input  logic                   irq_clr,
   output logic                   irq
`endif
);

   typedef enum logic {IDLE, PENDING} state_t;

   state_t              state;
   logic                boundary;
   logic                wr_valid;
   logic                commit;
   logic [NUM_CH-1:0]   ch_wr;

   assign boundary = count_en &&
                     (( up_down && (count == COUNT_WIDTH'(COUNT_END))) ||
                      (!up_down && (count == COUNT_WIDTH'(COUNT_START))));
   assign wr_valid = cmp_wr_en && (int'(cmp_wr_sel) < NUM_CH);
   assign commit   = (state == PENDING) && boundary;

   always_comb begin
      ch_wr = '0;
      for (int i = 0; i < NUM_CH; i++)
         ch_wr[i] = wr_valid && (int'(cmp_wr_sel) == i);
   end

   pwm_compare_ch #(
      .COUNT_WIDTH (COUNT_WIDTH),
      .COUNT_START (COUNT_START)
   ) u_ch [NUM_CH-1:0] (
      .clk         (clk),
      .rst         (rst),
      .count_en    (count_en),
      .count       (count),
      .wr_en       (ch_wr),
      .wr_data     (cmp_wr_data),
      .commit      (commit),
      .pwm_out     (pwm_out),
      .match_pulse (match_pulse)
   );

   // a write coinciding with a commit keeps the FSM pending for the next boundary
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         update_pending <= 1'b0;
         update_done    <= 1'b0;
         period_pulse   <= 1'b0;
      end else begin
         period_pulse <= boundary;
         update_done  <= 1'b0;
         case (state)
            IDLE: begin
               if (wr_valid) begin
                  state          <= PENDING;
                  update_pending <= 1'b1;
               end
            end
            PENDING: begin
               if (boundary) begin
                  update_done <= 1'b1;
                  if (!wr_valid) begin
                     state          <= IDLE;
                     update_pending <= 1'b0;
                  end
               end
            end
            default: begin
               state          <= IDLE;
               update_pending <= 1'b0;
            end
         endcase
      end
   end

`ifdef PWM_COMPARE_IRQ_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         irq <= 1'b0;
      else if ((|match_pulse) || update_done)
         irq <= 1'b1;
      else if (irq_clr)
         irq <= 1'b0;
   end
`endif

endmodule

// File: tb/tb_pwm_compare.sv
// Scoreboard bench for pwm_compare: a behavioural model pushes expected outputs per
// driven cycle, a monitor pops and compares them one cycle later.

module tb_pwm_compare;

   localparam int W   = 4;
   localparam int NCH = 2;
   localparam int CS  = 2;
   localparam int CE  = 11;
   localparam int SW  = (NCH > 1) ? $clog2(NCH) : 1;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           count_en = 1'b0;
   logic           up_down = 1'b1;
   logic [W-1:0]   count = W'(CS);
   logic           cmp_wr_en = 1'b0;
   logic [SW-1:0]  cmp_wr_sel = '0;
   logic [W-1:0]   cmp_wr_data = '0;
   logic           irq_clr = 1'b0;
   logic [NCH-1:0] pwm_out;
   logic [NCH-1:0] match_pulse;
   logic           period_pulse;
   logic           update_pending;
   logic           update_done;
   logic           irq;

   always #5 clk = ~clk;

   pwm_compare #(
      .COUNT_WIDTH (W),
      .NUM_CH      (NCH),
      .COUNT_START (CS),
      .COUNT_END   (CE)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .count_en       (count_en),
      .up_down        (up_down),
      .count          (count),
      .cmp_wr_en      (cmp_wr_en),
      .cmp_wr_sel     (cmp_wr_sel),
      .cmp_wr_data    (cmp_wr_data),
      .pwm_out        (pwm_out),
      .match_pulse    (match_pulse),
      .period_pulse   (period_pulse),
      .update_pending (update_pending),
      .update_done    (update_done)
`ifdef PWM_COMPARE_IRQ_EN
      ,
      .irq_clr        (irq_clr),
      .irq            (irq)
`endif
   );

`ifndef PWM_COMPARE_IRQ_EN
   assign irq = 1'b0;
`endif

   typedef struct {
      logic [NCH-1:0] pwm;
      logic [NCH-1:0] match;
      logic           period;
      logic           pending;
      logic           done;
      logic           irq;
   } exp_t;

   exp_t         sb_q[$];
   int           n_chk = 0;
   int           n_err = 0;
   int           pwm0_hi = 0;
   int           pwm1_hi = 0;
   int           match0_n = 0;
   int           per_n = 0;

   logic [W-1:0] m_act [NCH];
   logic [W-1:0] m_shd [NCH];
   logic         m_pend;
   exp_t         m_prev;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < NCH; i++) begin
         m_act[i] = W'(CS);
         m_shd[i] = W'(CS);
      end
      m_pend         = 1'b0;
      m_prev.pwm     = '0;
      m_prev.match   = '0;
      m_prev.period  = 1'b0;
      m_prev.pending = 1'b0;
      m_prev.done    = 1'b0;
      m_prev.irq     = 1'b0;
   endtask

   task automatic clr_cnt();
      pwm0_hi  = 0;
      pwm1_hi  = 0;
      match0_n = 0;
      per_n    = 0;
   endtask

   // called at a negedge: drive one cycle, predict the registered outputs, advance the counter
   task automatic step(input logic en, input logic ud, input logic wr, input int sel, input int data);
      exp_t e;
      logic bnd, commit, wv;
      count_en    = en;
      up_down     = ud;
      cmp_wr_en   = wr;
      cmp_wr_sel  = SW'(sel);
      cmp_wr_data = W'(data);
      bnd = en && ((ud && count == W'(CE)) || (!ud && count == W'(CS)));
      for (int i = 0; i < NCH; i++) begin
         e.pwm[i]   = (count < m_act[i]);
         e.match[i] = en && (count == m_act[i]);
      end
      e.period  = bnd;
      commit    = m_pend && bnd;
      e.done    = commit;
      wv        = wr && (sel < NCH);
      e.pending = wv ? 1'b1 : (commit ? 1'b0 : m_pend);
      e.irq     = ((|m_prev.match) || m_prev.done) ? 1'b1 : (irq_clr ? 1'b0 : m_prev.irq);
      sb_q.push_back(e);
      m_pend = e.pending;
      if (commit) m_act = m_shd;
      if (wv) m_shd[sel] = W'(data);
      m_prev = e;
      @(negedge clk);
      if (en) begin
         if (ud) count = (count == W'(CE)) ? W'(CS) : count + 1'b1;
         else    count = (count == W'(CS)) ? W'(CE) : count - 1'b1;
      end
   endtask

   task automatic idle(input int n, input logic ud);
      for (int k = 0; k < n; k++) step(1'b1, ud, 1'b0, 0, 0);
   endtask

   always @(posedge clk) begin : mon
      exp_t e;
      #1;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk("pwm_out", 32'(pwm_out), 32'(e.pwm));
         chk("match_pulse", 32'(match_pulse), 32'(e.match));
         chk("period_pulse", 32'(period_pulse), 32'(e.period));
         chk("update_pending", 32'(update_pending), 32'(e.pending));
         chk("update_done", 32'(update_done), 32'(e.done));
`ifdef PWM_COMPARE_IRQ_EN
         chk("irq", 32'(irq), 32'(e.irq));
`endif
         pwm0_hi  += int'(pwm_out[0]);
         pwm1_hi  += int'(pwm_out[1]);
         match0_n += int'(match_pulse[0]);
         per_n    += int'(period_pulse);
      end
   end

   initial begin
      m_reset();
      repeat (2) @(negedge clk);
      chk("rst_pwm", 32'(pwm_out), 32'(0));
      chk("rst_period", 32'(period_pulse), 32'(0));
      chk("rst_pending", 32'(update_pending), 32'(0));
      chk("rst_done", 32'(update_done), 32'(0));
      rst = 1'b1;

      // no writes: pwm stays low, one period pulse per 10 cycles
      idle(12, 1'b1);
      clr_cnt();
      idle(10, 1'b1);
      chk("s1_pwm0_hi", 32'(pwm0_hi), 32'(0));
      chk("s1_period_n", 32'(per_n), 32'(1));

      // ch0=6 written at count 4
      while (count != 4'd4) step(1'b1, 1'b1, 1'b0, 0, 0);
      step(1'b1, 1'b1, 1'b1, 0, 6);
      idle(12, 1'b1);
      clr_cnt();
      idle(10, 1'b1);
      chk("s2_pwm0_hi", 32'(pwm0_hi), 32'(4));
      chk("s2_match0_n", 32'(match0_n), 32'(1));

      // several writes in one pending window
      while (count != 4'd3) step(1'b1, 1'b1, 1'b0, 0, 0);
      step(1'b1, 1'b1, 1'b1, 1, 12);
      step(1'b1, 1'b1, 1'b1, 1, 2);
      step(1'b1, 1'b1, 1'b1, 0, 9);
      idle(12, 1'b1);
      clr_cnt();
      idle(10, 1'b1);
      chk("s3_pwm0_hi", 32'(pwm0_hi), 32'(7));
      chk("s3_pwm1_hi", 32'(pwm1_hi), 32'(0));

      // write on the boundary cycle with an older value pending
      while (count != 4'd5) step(1'b1, 1'b1, 1'b0, 0, 0);
      step(1'b1, 1'b1, 1'b1, 0, 5);
      while (count != 4'(CE)) step(1'b1, 1'b1, 1'b0, 0, 0);
      step(1'b1, 1'b1, 1'b1, 0, 8);
      chk("s4_pend_after_bnd", 32'(update_pending), 32'(1));
      clr_cnt();
      idle(10, 1'b1);
      chk("s4_pwm0_hi_cmp5", 32'(pwm0_hi), 32'(3));
      clr_cnt();
      idle(10, 1'b1);
      chk("s4_pwm0_hi_cmp8", 32'(pwm0_hi), 32'(6));

      // down counting with ch0=7, then a count_en gap at count 5
      step(1'b1, 1'b0, 1'b1, 0, 7);
      idle(22, 1'b0);
      clr_cnt();
      idle(10, 1'b0);
      chk("s5_pwm0_hi", 32'(pwm0_hi), 32'(5));
      chk("s5_period_n", 32'(per_n), 32'(1));
      while (count != 4'd5) step(1'b1, 1'b0, 1'b0, 0, 0);
      clr_cnt();
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 0, 0);
      chk("s5_hold_pwm0", 32'(pwm0_hi), 32'(3));
      chk("s5_hold_match", 32'(match0_n), 32'(0));
      chk("s5_hold_period", 32'(per_n), 32'(0));

`ifdef PWM_COMPARE_IRQ_EN
      // ch0 active is 7; clear coinciding with the match pulse must not win
      irq_clr = 1'b1;
      idle(3, 1'b1);
      irq_clr = 1'b0;
      while (count != 4'd8) step(1'b1, 1'b1, 1'b0, 0, 0);
      irq_clr = 1'b1;
      step(1'b1, 1'b1, 1'b0, 0, 0);
      irq_clr = 1'b0;
      chk("irq_set_wins", 32'(irq), 32'(1));
      for (int k = 0; k < 40; k++) begin
         irq_clr = 1'($urandom_range(0, 1));
         step(1'b1, 1'b1, 1'b0, 0, 0);
      end
      irq_clr = 1'b0;
`endif

      // randomised traffic through both directions
      for (int k = 0; k < 300; k++) begin
         step(1'($urandom_range(0, 3) != 0), (k / 60) % 2 == 0,
              1'($urandom_range(0, 9) == 0), int'($urandom_range(0, NCH - 1)),
              int'($urandom_range(0, 15)));
      end

      // reset while pending at count 9
      while (count != 4'd8) step(1'b1, 1'b1, 1'b0, 0, 0);
      step(1'b1, 1'b1, 1'b1, 0, 9);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_pwm", 32'(pwm_out), 32'(0));
      chk("arst_match", 32'(match_pulse), 32'(0));
      chk("arst_period", 32'(period_pulse), 32'(0));
      chk("arst_pending", 32'(update_pending), 32'(0));
      chk("arst_done", 32'(update_done), 32'(0));
      chk("arst_irq", 32'(irq), 32'(0));
      sb_q.delete();
      m_reset();
      count = W'(CS);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      idle(12, 1'b1);
      chk("s6_pending", 32'(update_pending), 32'(0));
      clr_cnt();
      idle(10, 1'b1);
      chk("s6_pwm0_hi", 32'(pwm0_hi), 32'(0));

      @(negedge clk);
      chk("sb_drain", 32'(sb_q.size()), 32'(0));
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
